// File: rtl/card_pkg.sv
// Shared card encodings, FSM states and helpers for the random card revealer.
package card_pkg;

  // The card state lives in the top STATE_W bits of each card code.
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    HIDDEN   = 2'b00,
    REVEALED = 2'b01,
    MATCHED  = 2'b10,
    RSVD     = 2'b11
  } card_state_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PICK,
    PROBE,
    WRITE,
    FINISH
  } rev_state_t;

  function automatic logic is_hidden(input logic [STATE_W-1:0] st);
    return st == HIDDEN;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Galois LFSR with a loadable seed; a zero load falls back to the
// reset seed so the register can never lock up at all-zeros.
module lfsr_gen #(
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'h5A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [LFSR_W-1:0] ld_val,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= LFSR_SEED;
    end else if (ld) begin
      q <= (ld_val == '0) ? LFSR_SEED : ld_val;
    end else if (q[0]) begin
      q <= (q >> 1) ^ LFSR_TAPS;
    end else begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/random_card_revealer.sv
// Reveals up to req_count distinct face-down cards picked pseudo-randomly from
// the board snapshot, then publishes the whole updated board with a done pulse.
module random_card_revealer
  import card_pkg::*;
#(
  parameter int                N_CARDS    = 16,
  parameter int                CARD_W     = 5,
  parameter int                LFSR_W     = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'h5A,
  parameter int                MAX_REVEAL = 4,
  localparam int               IDX_W      = (N_CARDS > 1) ? $clog2(N_CARDS) : 1,
  localparam int               CNT_W      = $clog2(MAX_REVEAL + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [CNT_W-1:0]                req_count,
  input  logic                            seed_ld,
  input  logic [LFSR_W-1:0]               seed_in,
  input  logic [N_CARDS-1:0][CARD_W-1:0]  arr_cards_in,
  output logic [N_CARDS-1:0][CARD_W-1:0]  arr_cards_out,
  output logic [IDX_W-1:0]                last_idx,
  output logic [CNT_W-1:0]                revealed,
  output logic                            busy,
  output logic                            done,
  output logic                            none_left
);

  localparam int                HC_W        = $clog2(N_CARDS + 1);
  localparam logic [IDX_W:0]    N_EXT       = (IDX_W + 1)'(N_CARDS);
  localparam logic [IDX_W-1:0]  LAST_CARD   = IDX_W'(N_CARDS - 1);
  localparam logic [HC_W-1:0]   PROBE_LIMIT = HC_W'(N_CARDS - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT     = CNT_W'(MAX_REVEAL);

  rev_state_t                     state;
  logic [N_CARDS-1:0][CARD_W-1:0] board;
  logic [CNT_W-1:0]               target;
  logic [CNT_W-1:0]               req_clamped;
  logic [HC_W-1:0]                hcnt;
  logic [HC_W-1:0]                hidden_in;
  logic [HC_W-1:0]                probe_cnt;
  logic [IDX_W-1:0]               probe_idx;
  logic [IDX_W-1:0]               pick_idx;
  logic [IDX_W:0]                 raw_ext;
  logic [LFSR_W-1:0]              lfsr_q;
  logic                           lfsr_unused;

  lfsr_gen #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .ld     (seed_ld),
    .ld_val (seed_in),
    .q      (lfsr_q)
  );

  // Only the low IDX_W bits index the board; the rest just keep the sequence long.
  assign lfsr_unused = ^lfsr_q[LFSR_W-1:IDX_W];
  assign raw_ext     = {1'b0, lfsr_q[IDX_W-1:0]};
  assign pick_idx    = (raw_ext >= N_EXT) ? IDX_W'(raw_ext - N_EXT) : lfsr_q[IDX_W-1:0];

  always_comb begin
    hidden_in = '0;
    for (int i = 0; i < N_CARDS; i++) begin
      if (is_hidden(arr_cards_in[i][CARD_W-1 -: STATE_W])) begin
        hidden_in = hidden_in + HC_W'(1);
      end
    end
  end

  always_comb begin
    if (req_count == '0) begin
      req_clamped = CNT_W'(1);
    end else if (req_count > MAX_CNT) begin
      req_clamped = MAX_CNT;
    end else begin
      req_clamped = req_count;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      board         <= '0;
      target        <= '0;
      hcnt          <= '0;
      probe_idx     <= '0;
      probe_cnt     <= '0;
      arr_cards_out <= '0;
      last_idx      <= '0;
      revealed      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      none_left     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          board     <= arr_cards_in;
          target    <= req_clamped;
          revealed  <= '0;
          none_left <= 1'b0;
          hcnt      <= hidden_in;
          if (hidden_in == '0) begin
            none_left <= 1'b1;
            state     <= FINISH;
          end else begin
            state <= PICK;
          end
        end
        PICK: begin
          probe_idx <= pick_idx;
          probe_cnt <= '0;
          state     <= PROBE;
        end
        PROBE: begin
          // Linear probe forward from the random start until a hidden card turns up.
          if (is_hidden(board[probe_idx][CARD_W-1 -: STATE_W])) begin
            state <= WRITE;
          end else if (probe_cnt == PROBE_LIMIT) begin
            none_left <= 1'b1;
            state     <= FINISH;
          end else begin
            probe_idx <= (probe_idx == LAST_CARD) ? '0 : probe_idx + IDX_W'(1);
            probe_cnt <= probe_cnt + HC_W'(1);
          end
        end
        WRITE: begin
          board[probe_idx][CARD_W-1 -: STATE_W] <= REVEALED;
          last_idx <= probe_idx;
          revealed <= revealed + CNT_W'(1);
          hcnt     <= hcnt - HC_W'(1);
          if ((revealed + CNT_W'(1)) == target) begin
            state <= FINISH;
          end else if (hcnt == HC_W'(1)) begin
            none_left <= 1'b1;
            state     <= FINISH;
          end else begin
            state <= PICK;
          end
        end
        FINISH: begin
          arr_cards_out <= board;
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_random_card_revealer.sv
// Randomised bench for random_card_revealer: a 16-card and a 12-card instance
// checked against a request-level model driven by a tracked LFSR value.
module tb_random_card_revealer;

  localparam int MAXR = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            start_a = 0, seed_ld_a = 0, busy_a, done_a, nl_a;
  logic [2:0]      req_a = 0, rev_a;
  logic [7:0]      seed_a = 0;
  logic [15:0][4:0] in_a = '0, out_a;
  logic [3:0]      last_a;

  logic            start_b = 0, seed_ld_b = 0, busy_b, done_b, nl_b;
  logic [2:0]      req_b = 0, rev_b;
  logic [7:0]      seed_b = 0;
  logic [11:0][4:0] in_b = '0, out_b;
  logic [3:0]      last_b;

  random_card_revealer dut_a (
    .clk(clk), .rst(rst), .start(start_a), .req_count(req_a), .seed_ld(seed_ld_a),
    .seed_in(seed_a), .arr_cards_in(in_a), .arr_cards_out(out_a), .last_idx(last_a),
    .revealed(rev_a), .busy(busy_a), .done(done_a), .none_left(nl_a)
  );

  random_card_revealer #(.N_CARDS(12)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .req_count(req_b), .seed_ld(seed_ld_b),
    .seed_in(seed_b), .arr_cards_in(in_b), .arr_cards_out(out_b), .last_idx(last_b),
    .revealed(rev_b), .busy(busy_b), .done(done_b), .none_left(nl_b)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] step(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  // Tracked LFSR value per instance: seed load wins, otherwise advance every clock.
  logic [7:0] m_lfsr_a, m_lfsr_b;
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr_a <= 8'h5A;
    else      m_lfsr_a <= seed_ld_a ? ((seed_a == 0) ? 8'h5A : seed_a) : step(m_lfsr_a);
  end
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr_b <= 8'h5A;
    else      m_lfsr_b <= seed_ld_b ? ((seed_b == 0) ? 8'h5A : seed_b) : step(m_lfsr_b);
  end

  logic [4:0] cur_in[64];
  logic [4:0] exp_board[64];
  logic [4:0] obs_board[64];
  int  exp_last[2];
  int  exp_rev, exp_cyc;
  bit  exp_nl;
  int  obs_last, obs_rev, obs_cyc;
  bit  obs_nl, obs_done;

  task automatic model_request(input int sel, input logic [7:0] l0, input int req);
    int n, target, hid, idx, p;
    bit stop;
    logic [7:0] s;
    n = sel ? 12 : 16;
    target = (req == 0) ? 1 : ((req > MAXR) ? MAXR : req);
    hid = 0;
    for (int i = 0; i < n; i++) begin
      exp_board[i] = cur_in[i];
      if (cur_in[i][4:3] == 2'b00) hid++;
    end
    exp_rev = 0; exp_nl = 0; exp_cyc = 2;
    if (hid == 0) begin
      exp_nl = 1;
    end else begin
      s = step(step(l0));
      stop = 0;
      while (!stop) begin
        idx = int'(s[3:0]);
        if (idx >= n) idx = idx - n;
        p = 1;
        while (exp_board[idx][4:3] != 2'b00) begin
          idx = (idx + 1) % n;
          p++;
        end
        exp_board[idx][4:3] = 2'b01;
        exp_last[sel] = idx;
        exp_rev++;
        hid--;
        exp_cyc += p + 2;
        if (exp_rev == target) stop = 1;
        else if (hid == 0) begin exp_nl = 1; stop = 1; end
        else for (int k = 0; k < p + 2; k++) s = step(s);
      end
    end
  endtask

  task automatic gen_board(input int n, input int mode);
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 7);
      cur_in[i][2:0] = 3'($urandom_range(0, 7));
      if (mode == 1)      cur_in[i][4:3] = 2'b00;
      else if (mode == 2) cur_in[i][4:3] = 2'($urandom_range(1, 3));
      else                cur_in[i][4:3] = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
    end
  endtask

  task automatic run_request(input int sel, input int req, input bit extra_start);
    logic [7:0] l0;
    int n;
    n = sel ? 12 : 16;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (sel == 1) in_b[i] = cur_in[i];
      else          in_a[i] = cur_in[i];
    end
    if (sel == 1) begin req_b = 3'(req); start_b = 1; l0 = m_lfsr_b; end
    else          begin req_a = 3'(req); start_a = 1; l0 = m_lfsr_a; end
    model_request(sel, l0, req);
    @(negedge clk);
    start_a = 0; start_b = 0;
    obs_done = 0; obs_cyc = 0;
    for (int c = 1; c <= 400 && !obs_done; c++) begin
      @(posedge clk);
      #1;
      if (extra_start && c == 2) begin if (sel == 1) start_b = 1; else start_a = 1; end
      if (extra_start && c == 3) begin start_a = 0; start_b = 0; end
      if (((sel == 1) ? done_b : done_a) === 1'b1) begin obs_done = 1; obs_cyc = c; end
    end
    for (int i = 0; i < n; i++) obs_board[i] = (sel == 1) ? out_b[i] : out_a[i];
    obs_last = (sel == 1) ? int'(last_b) : int'(last_a);
    obs_rev  = (sel == 1) ? int'(rev_b)  : int'(rev_a);
    obs_nl   = (sel == 1) ? nl_b : nl_a;
    checks++;
    if (!obs_done) begin errors++; $display("[TB] FAIL done_timeout: done not seen within 400 cycles (sel %0d)", sel); end
  endtask

  function automatic int board_diffs(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) if (obs_board[i] !== exp_board[i]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    int dones;
    #12;
    checks++; if (out_a !== '0)    begin errors++; $display("[TB] FAIL reset_board: got %h expected 0", out_a); end
    checks++; if (last_a !== 4'd0) begin errors++; $display("[TB] FAIL reset_last: got %0d expected 0", last_a); end
    checks++; if (rev_a !== 3'd0)  begin errors++; $display("[TB] FAIL reset_revealed: got %0d expected 0", rev_a); end
    checks++; if ({busy_a, done_a, nl_a} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy_a, done_a, nl_a}); end
    @(negedge clk); rst = 1;
    // Abort a request mid-flight.
    gen_board(16, 1);
    @(negedge clk);
    for (int i = 0; i < 16; i++) in_a[i] = cur_in[i];
    req_a = 3'd4; start_a = 1;
    @(negedge clk); start_a = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1;
    checks++; if ({busy_a, done_a, nl_a, rev_a, last_a} !== '0) begin errors++; $display("[TB] FAIL midrun_reset_outputs: got %b expected 0", {busy_a, done_a, nl_a, rev_a, last_a}); end
    checks++; if (out_a !== '0) begin errors++; $display("[TB] FAIL midrun_reset_board: got %h expected 0", out_a); end
    exp_last[0] = 0; exp_last[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done_a === 1'b1 || busy_a === 1'b1) dones++; end
    checks++; if (dones != 0) begin errors++; $display("[TB] FAIL no_done_after_reset: got %0d active cycles expected 0", dones); end
    // First pick after reset comes from the reset seed.
    gen_board(16, 1);
    run_request(0, 1, 0);
    checks++; if (obs_last != exp_last[0]) begin errors++; $display("[TB] FAIL reset_seed_pick: got %0d expected %0d", obs_last, exp_last[0]); end
    checks++; if (obs_cyc != exp_cyc) begin errors++; $display("[TB] FAIL reset_seed_latency: got %0d expected %0d", obs_cyc, exp_cyc); end
  endtask

  task automatic test_single_reveal();
    int changed;
    @(negedge clk); seed_ld_a = 1; seed_a = 8'h03;
    @(negedge clk); seed_ld_a = 0;
    gen_board(16, 1);
    run_request(0, 1, 0);
    changed = 0;
    for (int i = 0; i < 16; i++) if (obs_board[i] !== cur_in[i]) changed++;
    checks++; if (obs_cyc != exp_cyc) begin errors++; $display("[TB] FAIL single_latency: got %0d expected %0d", obs_cyc, exp_cyc); end
    checks++; if (changed != 1) begin errors++; $display("[TB] FAIL single_changed: got %0d expected 1", changed); end
    checks++; if (obs_board[obs_last & 15] !== {2'b01, cur_in[obs_last & 15][2:0]}) begin errors++; $display("[TB] FAIL single_card: got %b expected 01 state at last_idx", obs_board[obs_last & 15]); end
    checks++; if (obs_last != exp_last[0]) begin errors++; $display("[TB] FAIL single_last: got %0d expected %0d", obs_last, exp_last[0]); end
    checks++; if (obs_rev != 1 || obs_nl != 0) begin errors++; $display("[TB] FAIL single_counts: got rev %0d nl %0d expected 1 0", obs_rev, obs_nl); end
  endtask

  task automatic test_one_hidden();
    for (int i = 0; i < 16; i++) cur_in[i] = {2'b10, 3'(i)};
    cur_in[7] = {2'b00, 3'd5};
    run_request(0, 2, 0);
    checks++; if (obs_last != 7) begin errors++; $display("[TB] FAIL one_hidden_last: got %0d expected 7", obs_last); end
    checks++; if (obs_rev != 1 || obs_nl != 1) begin errors++; $display("[TB] FAIL one_hidden_counts: got rev %0d nl %0d expected 1 1", obs_rev, obs_nl); end
    checks++; if (obs_board[7] !== 5'b01101) begin errors++; $display("[TB] FAIL one_hidden_card: got %b expected 01101", obs_board[7]); end
    checks++; if (obs_cyc > 21 || obs_cyc != exp_cyc) begin errors++; $display("[TB] FAIL one_hidden_latency: got %0d expected %0d", obs_cyc, exp_cyc); end
  endtask

  task automatic test_no_hidden();
    int prev;
    prev = exp_last[0];
    gen_board(16, 2);
    run_request(0, 3, 0);
    checks++; if (obs_cyc != 2) begin errors++; $display("[TB] FAIL no_hidden_latency: got %0d expected 2", obs_cyc); end
    checks++; if (board_diffs(16) != 0) begin errors++; $display("[TB] FAIL no_hidden_board: got %0d differing cards expected 0", board_diffs(16)); end
    checks++; if (obs_rev != 0 || obs_nl != 1) begin errors++; $display("[TB] FAIL no_hidden_counts: got rev %0d nl %0d expected 0 1", obs_rev, obs_nl); end
    checks++; if (obs_last != prev) begin errors++; $display("[TB] FAIL no_hidden_last_hold: got %0d expected %0d", obs_last, prev); end
  endtask

  task automatic test_wrap();
    logic [7:0] s;
    s = 8'h01;
    for (int c = 1; c < 256; c++) if (step(step(step(8'(c)))) % 16 == 14) begin s = 8'(c); break; end
    @(negedge clk); seed_ld_b = 1; seed_b = s;
    @(negedge clk); seed_ld_b = 0;
    for (int i = 0; i < 12; i++) cur_in[i] = {(i < 2) ? 2'b00 : 2'b10, 3'(i)};
    run_request(1, 1, 0);
    checks++; if (obs_last != 0) begin errors++; $display("[TB] FAIL wrap_last: got %0d expected 0", obs_last); end
    checks++; if (obs_cyc != 15) begin errors++; $display("[TB] FAIL wrap_latency: got %0d expected 15", obs_cyc); end
    checks++; if (board_diffs(12) != 0) begin errors++; $display("[TB] FAIL wrap_board: got %0d differing cards expected 0", board_diffs(12)); end
  endtask

  task automatic test_back_to_back();
    int changed, active;
    gen_board(16, 1);
    run_request(0, 7, 1);
    changed = 0;
    for (int i = 0; i < 16; i++) if (obs_board[i] === {2'b01, cur_in[i][2:0]}) changed++;
    checks++; if (changed != 4 || obs_rev != 4) begin errors++; $display("[TB] FAIL clamp_count: got %0d cards rev %0d expected 4", changed, obs_rev); end
    checks++; if (board_diffs(16) != 0 || obs_nl != 0) begin errors++; $display("[TB] FAIL clamp_board: got %0d diffs nl %0d expected 0 0", board_diffs(16), obs_nl); end
    checks++; if (obs_cyc != exp_cyc) begin errors++; $display("[TB] FAIL clamp_latency: got %0d expected %0d", obs_cyc, exp_cyc); end
    active = 0;
    repeat (6) begin @(posedge clk); #1; if (busy_a === 1'b1 || done_a === 1'b1) active++; end
    checks++; if (active != 0) begin errors++; $display("[TB] FAIL extra_start_ignored: got %0d active cycles expected 0", active); end
  endtask

  task automatic test_random();
    int sel, n, req, vbad;
    for (int it = 0; it < 1000; it++) begin
      sel = it % 2;
      n = sel ? 12 : 16;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        if (sel == 1) begin seed_ld_b = 1; seed_b = 8'($urandom_range(0, 255)); end
        else          begin seed_ld_a = 1; seed_a = 8'($urandom_range(0, 255)); end
        @(negedge clk); seed_ld_a = 0; seed_ld_b = 0;
      end
      gen_board(n, 0);
      req = $urandom_range(0, 7);
      run_request(sel, req, 0);
      vbad = 0;
      for (int i = 0; i < n; i++) begin
        if (obs_board[i][2:0] !== cur_in[i][2:0]) vbad++;
        if (cur_in[i][4:3] != 2'b00 && obs_board[i][4:3] !== cur_in[i][4:3]) vbad++;
      end
      checks++; if (vbad != 0) begin errors++; $display("[TB] FAIL rand_untouched it %0d: got %0d bad cards expected 0", it, vbad); end
      checks++; if (board_diffs(n) != 0) begin errors++; $display("[TB] FAIL rand_board it %0d: got %0d diffs expected 0", it, board_diffs(n)); end
      checks++; if (obs_last != exp_last[sel]) begin errors++; $display("[TB] FAIL rand_last it %0d: got %0d expected %0d", it, obs_last, exp_last[sel]); end
      checks++; if (obs_rev != exp_rev || obs_nl != exp_nl) begin errors++; $display("[TB] FAIL rand_counts it %0d: got rev %0d nl %0d expected %0d %0d", it, obs_rev, obs_nl, exp_rev, exp_nl); end
      checks++; if (obs_cyc != exp_cyc) begin errors++; $display("[TB] FAIL rand_latency it %0d: got %0d expected %0d", it, obs_cyc, exp_cyc); end
    end
  endtask

  initial begin
    exp_last[0] = 0;
    exp_last[1] = 0;
    test_reset();
    test_single_reveal();
    test_one_hidden();
    test_no_hidden();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
